iecdrv_sd_arbiter: RTL and testbench
====================================

# iecdrv_sd_arbiter

Multiplexes the per-drive sector request ports of a multi-drive IEC block (1..4 drives, each with its own `sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`, `sd_buff_din`) onto the single host SD-image channel in the `clk_sys` domain. Arbitrates round-robin, holds one drive's request until the host completes the sector, and steers `sd_ack` and buffer read-back data. Adds an acknowledge timeout and drive-reset withdrawal so a hung or reset drive cannot lock the channel.

## Interface
Parameters:
- `NDR`, 2: number of drives, legal 1..4.
- `TO_BITS`, 24: width of the REQ-state ack timeout counter.

Ports:
- `clk_sys`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `drv_rst`, in, NDR: per-drive reset, already in `clk_sys` domain.
- `drv_lba`, in, 32×NDR: per-drive sector LBA.
- `drv_rd`, in, NDR: per-drive read request, level, held until ack.
- `drv_wr`, in, NDR: per-drive write request, level, held until ack.
- `drv_ack`, out, NDR: per-drive ack, one-hot or zero.
- `drv_buff_din`, in, 8×NDR: per-drive buffer read-back data for writes.
- `host_lba`, out, 32: latched LBA of granted drive.
- `host_rd`, out, 1: read request to host.
- `host_wr`, out, 1: write request to host.
- `host_ack`, in, 1: host ack, high for the whole transfer.
- `host_buff_din`, out, 8: `drv_buff_din[grant]`.
- `grant`, out, 2: index of the owning drive.
- `busy`, out, 1: high in REQ, XFER and DONE.
- `timeout`, out, 1: one-cycle pulse on REQ abort.

`sd_buff_addr`, `sd_buff_dout` and `sd_buff_wr` are broadcast outside this block. Each drive gates them with its own `drv_ack`.

## Operation
- States: IDLE, REQ, XFER, DONE.
- Eligible drive `i`: `(drv_rd[i] | drv_wr[i]) & ~drv_rst[i]`.
- IDLE:
  - Scan from `last+1` (mod NDR) and pick the first eligible drive.
  - Set `grant` to that drive.
  - Latch `host_lba` from `drv_lba[grant]`.
  - Latch direction; read wins if the drive has both rd and wr asserted.
  - Clear the timeout counter and go to REQ.
- REQ:
  - Hold `host_rd` or `host_wr` high.
  - If `host_ack` is high, drop the request and go to XFER.
  - Else, if `drv_rst[grant]` is high, drop the request and go to IDLE.
  - Else, if the counter is all ones, pulse `timeout` and go to DONE.
  - Otherwise, increment the counter.
- XFER:
  - Stay while `host_ack` is high.
  - When `host_ack` falls, go to DONE.
  - Reset of the granted drive in XFER does not abort: the host owns the transfer, so the transfer completes with `drv_ack` masked.
- DONE:
  - One cycle.
  - `last <= grant`, then go to IDLE.
  - This cycle gives the drive time to drop its request line before the next scan.
- `drv_ack[grant]` is combinational: `host_ack & (state==REQ | state==XFER) & ~drv_rst[grant]`. All other bits are 0. It must not be registered: the first `sd_buff_wr` can coincide with the `host_ack` rise.
- `host_buff_din` is a combinational mux on `grant`.
- `host_lba` is stable from REQ entry until the next grant.
- NDR=1: the scan degenerates to drive 0, `grant` stays 0.
- Unused `grant` bits and `drv_ack` bits at or above NDR are driven 0.

## Timing
- Reset values:
  - state IDLE.
  - `host_rd`, `host_wr`, `busy`, `timeout`, `drv_ack`: 0.
  - `grant`: 0.
  - `host_lba`: 0.
  - `last`: NDR-1, so the first scan starts at drive 0.
- Request eligible in IDLE at cycle t → `host_rd`/`host_wr` and `busy` high at t+1.
- `host_ack` high at cycle t in REQ:
  - `drv_ack[grant]` high in cycle t (combinational).
  - `host_rd`/`host_wr` low at t+1.
- `host_ack` low at cycle t in XFER → DONE at t+1 → IDLE at t+2.
  - Earliest next `host_rd` is t+3.
  - Back-to-back grants are separated by at least 2 idle request cycles.
- Timeout: REQ held for 2^TO_BITS cycles with no ack → `timeout` pulses one cycle, concurrent with the REQ→DONE transition.
- Simultaneous requests: strictly round-robin relative to `last`, never fixed priority.
- An async `reset` assertion mid-XFER returns to IDLE immediately. The host is expected to be reset by the same source.

## Test plan
- **Single read:** drive 1 raises rd, LBA 0x00000123.
  - Required: `host_rd` high one cycle later, `host_lba`=0x123, `grant`=1.
  - Required: `host_ack` pulse of 512 cycles yields `drv_ack`=4'b0010 for exactly those cycles.
  - Required: `busy` falls 2 cycles after ack falls.
- **Round-robin:** drives 0, 1, 2 all request continuously with 4 drives.
  - Required: grant order 0, 1, 2, 0, 1, 2, and no drive is granted twice while another is pending.
- **Write read-back:** drive 3 wr, `drv_buff_din[3]`=0xA5, others 0x00.
  - Required: `host_buff_din`=0xA5 throughout REQ/XFER, `host_wr`=1, `host_rd`=0.
- **Timeout:** TO_BITS=4, no `host_ack`.
  - Required: `timeout` pulses exactly 16 cycles after REQ entry, with no `drv_ack`.
  - Required: the next eligible drive is then granted.
- **Reset of a drive:**
  - `drv_rst[grant]` asserted in REQ: request dropped next cycle, and another pending drive is granted.
  - Asserted in XFER: transfer completes, `drv_ack` stays 0, and `host_ack` fall still leads to DONE.
- **Async reset:** `reset` asserted mid-XFER.
  - Required: all outputs 0 within the same cycle.
  - Required: after release, a drive 0 request is granted first.

Source files
------------

// File: rtl/iecdrv_sd_arbiter.sv
// rtl/iecdrv_sd_arbiter.sv - round-robin multiplexer of per-drive sector requests onto one host SD channel
module iecdrv_sd_arbiter #(
    parameter int NDR     = 2,
    parameter int TO_BITS = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [NDR-1:0]    drv_rst,
    input  logic [32*NDR-1:0] drv_lba,
    input  logic [NDR-1:0]    drv_rd,
    input  logic [NDR-1:0]    drv_wr,
    output logic [NDR-1:0]    drv_ack,
    input  logic [8*NDR-1:0]  drv_buff_din,
    output logic [31:0]       host_lba,
    output logic              host_rd,
    output logic              host_wr,
    input  logic              host_ack,
    output logic [7:0]        host_buff_din,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t             state;
    logic [1:0]         last;
    logic [TO_BITS-1:0] cnt;
    logic [NDR-1:0]     elig;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic               pick_rd;
    logic [31:0]        pick_lba;
    logic               grant_rst;

    // A drive held in reset never competes, even with a stale request line
    assign elig = (drv_rd | drv_wr) & ~drv_rst;

    // Scan from one past the last owner; the nearest eligible drive wins (later k overwritten by nearer k)
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_rd    = 1'b0;
        pick_lba   = '0;
        for (int k = NDR; k >= 1; k--) begin
            for (int i = 0; i < NDR; i++) begin
                if (i == (int'(last) + k) % NDR && elig[i]) begin
                    pick_valid = 1'b1;
                    pick_idx   = 2'(i);
                    pick_rd    = drv_rd[i];
                    pick_lba   = drv_lba[32*i +: 32];
                end
            end
        end
    end

    // Steering back to the owner; ack stays combinational so the first buffer write lines up with the host ack
    always_comb begin
        grant_rst     = 1'b0;
        host_buff_din = '0;
        drv_ack       = '0;
        for (int i = 0; i < NDR; i++) begin
            if (grant == 2'(i)) begin
                grant_rst     = drv_rst[i];
                host_buff_din = drv_buff_din[8*i +: 8];
                drv_ack[i]    = host_ack & ((state == REQ) | (state == XFER)) & ~drv_rst[i];
            end
        end
    end

    // Channel ownership FSM with registered host-side outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= 2'(NDR - 1);
            host_lba <= '0;
            host_rd  <= 1'b0;
            host_wr  <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= pick_idx;
                        host_lba <= pick_lba;
                        host_rd  <= pick_rd;
                        host_wr  <= ~pick_rd;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (host_ack) begin
                        host_rd <= 1'b0;
                        host_wr <= 1'b0;
                        state   <= XFER;
                    end else if (grant_rst) begin
                        // Withdrawn before the host took it: no DONE, last owner unchanged
                        host_rd <= 1'b0;
                        host_wr <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (&cnt) begin
                        host_rd <= 1'b0;
                        host_wr <= 1'b0;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    // The host owns the transfer; a drive reset only masks its ack
                    if (!host_ack) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Gives the drive a cycle to drop its request before the next scan
                    last  <= grant;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// tb/tb_iecdrv_sd_arbiter.sv - self-checking bench for iecdrv_sd_arbiter
module tb_iecdrv_sd_arbiter;

    localparam int NDR     = 4;
    localparam int TO_BITS = 4;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [NDR-1:0]    drv_rst;
    logic [32*NDR-1:0] drv_lba;
    logic [NDR-1:0]    drv_rd;
    logic [NDR-1:0]    drv_wr;
    logic [NDR-1:0]    drv_ack;
    logic [8*NDR-1:0]  drv_buff_din;
    logic [31:0]       host_lba;
    logic              host_rd;
    logic              host_wr;
    logic              host_ack;
    logic [7:0]        host_buff_din;
    logic [1:0]        grant;
    logic              busy;
    logic              timeout;

    iecdrv_sd_arbiter #(.NDR(NDR), .TO_BITS(TO_BITS)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .drv_rst       (drv_rst),
        .drv_lba       (drv_lba),
        .drv_rd        (drv_rd),
        .drv_wr        (drv_wr),
        .drv_ack       (drv_ack),
        .drv_buff_din  (drv_buff_din),
        .host_lba      (host_lba),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .grant         (grant),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        int         ack_len;
        logic [1:0] g;
        logic       is_rd;
        logic [7:0] buff;
    } vec_t;

    typedef struct {
        logic [1:0]  g;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic [7:0]  buff;
    } exp_t;

    vec_t vecs[11];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic prev_req = 1'b0;

    function automatic logic [31:0] lba_of(input int i);
        return 32'h23 + 32'(i) * 32'h100;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input int g, input logic rd);
        exp_t e;
        e.g    = 2'(g);
        e.rd   = rd;
        e.wr   = ~rd;
        e.lba  = lba_of(g);
        e.buff = drv_buff_din[8*g +: 8];
        exp_q.push_back(e);
    endtask

    // Scoreboard: each new host request is matched against the oldest expected grant
    always @(negedge clk_sys) begin
        exp_t e;
        if ((host_rd | host_wr) && !prev_req) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant", {grant, host_rd, host_wr, host_lba, host_buff_din},
                      {e.g, e.rd, e.wr, e.lba, e.buff});
            end
        end
        prev_req = host_rd | host_wr;
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_sys);
            if (host_rd | host_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_request", 64'd0, 64'd1);
    endtask

    // Ack for len cycles, count cycles with the right ack and read-back data, then watch DONE and IDLE
    task automatic ack_xfer(input int len, input logic [3:0] oh, input logic [7:0] buff, input string nm);
        int good;
        good = 0;
        check({nm, "_pre_ack"}, drv_ack, 0);
        host_ack = 1'b1;
        #1;
        if (drv_ack === oh && host_buff_din === buff) good++;
        for (int c = 1; c < len; c++) begin
            @(negedge clk_sys);
            if (drv_ack === oh && host_buff_din === buff) good++;
        end
        @(negedge clk_sys);
        host_ack = 1'b0;
        #1;
        check({nm, "_ack_cycles"}, good, len);
        check({nm, "_ack_low"}, drv_ack, 0);
        @(negedge clk_sys);
        check({nm, "_busy_done"}, busy, 1);
        @(negedge clk_sys);
        check({nm, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int k;
        int bad;
        logic any_ack;

        vecs[0]  = '{4'b0010, 4'b0000, 512, 2'd1, 1'b1, 8'h00};
        vecs[1]  = '{4'b0000, 4'b1000, 5,   2'd3, 1'b0, 8'hA5};
        vecs[2]  = '{4'b0111, 4'b0000, 3,   2'd0, 1'b1, 8'h00};
        vecs[3]  = '{4'b0111, 4'b0000, 3,   2'd1, 1'b1, 8'h00};
        vecs[4]  = '{4'b0111, 4'b0000, 3,   2'd2, 1'b1, 8'h00};
        vecs[5]  = '{4'b0111, 4'b0000, 3,   2'd0, 1'b1, 8'h00};
        vecs[6]  = '{4'b0111, 4'b0000, 3,   2'd1, 1'b1, 8'h00};
        vecs[7]  = '{4'b0111, 4'b0000, 3,   2'd2, 1'b1, 8'h00};
        vecs[8]  = '{4'b0001, 4'b0000, 0,   2'd0, 1'b1, 8'h00};
        vecs[9]  = '{4'b0011, 4'b0000, 2,   2'd1, 1'b1, 8'h00};
        vecs[10] = '{4'b0100, 4'b0100, 2,   2'd2, 1'b1, 8'h00};

        reset        = 1'b1;
        drv_rst      = '0;
        drv_rd       = '0;
        drv_wr       = '0;
        host_ack     = 1'b0;
        drv_buff_din = {8'hA5, 24'h000000};
        for (int i = 0; i < NDR; i++) drv_lba[32*i +: 32] = lba_of(i);

        @(negedge clk_sys);
        check("reset_ctrl", {host_rd, host_wr, busy, timeout, drv_ack, grant}, 0);
        check("reset_lba", host_lba, 0);
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        for (int i = 0; i < 11; i++) begin
            drv_rd = vecs[i].rd;
            drv_wr = vecs[i].wr;
            push_exp(vecs[i].g, vecs[i].is_rd);
            wait_req(ok);
            if (ok) begin
                if (vecs[i].ack_len > 0) begin
                    ack_xfer(vecs[i].ack_len, 4'b0001 << vecs[i].g, vecs[i].buff, $sformatf("vec%0d", i));
                end else begin
                    k = 0;
                    any_ack = 1'b0;
                    for (int c = 1; c <= 40; c++) begin
                        @(negedge clk_sys);
                        any_ack = any_ack | (|drv_ack);
                        if (timeout) begin
                            k = c;
                            break;
                        end
                    end
                    check("timeout_delay", k, 16);
                    check("timeout_no_ack", any_ack, 0);
                    @(negedge clk_sys);
                    check("timeout_pulse_end", {timeout, busy}, 0);
                end
            end
        end

        // Drive reset while its request waits: withdrawn next cycle, another drive gets the channel
        drv_rd = 4'b0101;
        drv_wr = 4'b0000;
        push_exp(0, 1'b1);
        wait_req(ok);
        drv_rst = 4'b0001;
        push_exp(2, 1'b1);
        @(negedge clk_sys);
        check("req_rst_drop", {host_rd, host_wr, busy, drv_ack}, 0);
        wait_req(ok);
        if (ok) ack_xfer(2, 4'b0100, 8'h00, "req_rst_next");
        drv_rst = '0;
        drv_rd  = '0;

        // Drive reset mid-transfer: transfer runs to completion with ack masked
        drv_rd = 4'b0010;
        push_exp(1, 1'b1);
        wait_req(ok);
        host_ack = 1'b1;
        @(negedge clk_sys);
        drv_rst = 4'b0010;
        #1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (drv_ack !== 4'b0000 || busy !== 1'b1) bad++;
            @(negedge clk_sys);
        end
        check("xfer_rst_ack_masked", bad, 0);
        host_ack = 1'b0;
        @(negedge clk_sys);
        check("xfer_rst_done", busy, 1);
        @(negedge clk_sys);
        check("xfer_rst_idle", busy, 0);
        drv_rst = '0;
        drv_rd  = '0;

        // Async reset mid-transfer, then the scan restarts at drive 0
        drv_rd = 4'b0100;
        push_exp(2, 1'b1);
        wait_req(ok);
        host_ack = 1'b1;
        @(negedge clk_sys);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {host_rd, host_wr, busy, timeout, drv_ack, grant, host_lba, host_buff_din}, 0);
        host_ack = 1'b0;
        drv_rd   = '0;
        @(negedge clk_sys);
        reset  = 1'b0;
        drv_rd = 4'b1001;
        push_exp(0, 1'b1);
        wait_req(ok);
        if (ok) ack_xfer(2, 4'b0001, 8'h00, "post_reset");
        drv_rd = '0;

        repeat (4) @(negedge clk_sys);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
